// File: rtl/vga_pattern_pipe.sv
// rtl/vga_pattern_pipe.sv - two-stage VGA test-pattern pixel pipe with active-low sync out
// Optional macro VGA_PATTERN_ANIM_EN builds the frame counter that animates patterns 3 and 4.
module vga_pattern_pipe #(
  parameter int         H_BAR_W       = 80,
  parameter logic [2:0] RESET_PATTERN = 3'd1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [9:0] i_hpos,
  input  logic [9:0] i_vpos,
  input  logic       i_visible,
  input  logic [2:0] i_pattern_sel,
  input  logic       i_pattern_valid,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic [2:0] o_red,
  output logic [2:0] o_grn,
  output logic [2:0] o_blu,
  output logic [7:0] o_frame_count,
  output logic [2:0] o_pattern
);

  logic       s1_hsync;
  logic       s1_vsync;
  logic       s1_vsync_q;
  logic [9:0] s1_hpos;
  logic [9:0] s1_vpos;
  logic       s1_visible;

  logic [2:0] active_pattern;
  logic [2:0] pending_sel;
  logic       pending_flag;
  logic       vs_rise;

  logic [2:0] bar_idx;
  logic [2:0] frame_grad;
  logic       frame_chk;
  logic [2:0] red_d;
  logic [2:0] grn_d;
  logic [2:0] blu_d;
  logic       unused_vpos_hi;

  assign vs_rise        = s1_vsync & ~s1_vsync_q;
  assign unused_vpos_hi = ^s1_vpos[9:8];

`ifdef VGA_PATTERN_ANIM_EN
  logic [7:0] frame_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      frame_count <= 8'd0;
    end else if (vs_rise) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  assign o_frame_count = frame_count;
  assign frame_grad    = frame_count[4:2];
  assign frame_chk     = frame_count[5];
`else
  assign o_frame_count = 8'd0;
  assign frame_grad    = 3'd0;
  assign frame_chk     = 1'b0;
`endif

  // Saturating bar index from a chain of threshold compares instead of a divider.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({22'd0, s1_hpos} >= 32'(k * H_BAR_W)) begin
        bar_idx = 3'(k);
      end
    end
  end

  always_comb begin
    red_d = 3'd0;
    grn_d = 3'd0;
    blu_d = 3'd0;
    if (s1_visible) begin
      case (active_pattern)
        3'd1: begin
          red_d = (s1_hpos[2:0] == 3'd0 || s1_vpos[2:0] == 3'd0) ? 3'b111 : 3'b000;
          grn_d = {3{s1_vpos[4]}};
          blu_d = {3{s1_hpos[4]}};
        end
        3'd2: begin
          red_d = {3{bar_idx[2]}};
          grn_d = {3{bar_idx[1]}};
          blu_d = {3{bar_idx[0]}};
        end
        3'd3: begin
          red_d = s1_hpos[7:5];
          grn_d = s1_vpos[7:5];
          blu_d = frame_grad;
        end
        3'd4: begin
          red_d = {3{s1_hpos[5] ^ s1_vpos[5] ^ frame_chk}};
          grn_d = {3{s1_hpos[5] ^ s1_vpos[5] ^ frame_chk}};
          blu_d = {3{s1_hpos[5] ^ s1_vpos[5] ^ frame_chk}};
        end
        3'd5: begin
          red_d = 3'b111;
          grn_d = 3'b111;
          blu_d = 3'b111;
        end
        default: begin
          red_d = 3'd0;
          grn_d = 3'd0;
          blu_d = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_hsync       <= 1'b0;
      s1_vsync       <= 1'b0;
      s1_vsync_q     <= 1'b0;
      s1_hpos        <= 10'd0;
      s1_vpos        <= 10'd0;
      s1_visible     <= 1'b0;
      o_hsync_n      <= 1'b1;
      o_vsync_n      <= 1'b1;
      o_red          <= 3'd0;
      o_grn          <= 3'd0;
      o_blu          <= 3'd0;
      active_pattern <= RESET_PATTERN;
      pending_sel    <= 3'd0;
      pending_flag   <= 1'b0;
    end else begin
      s1_hsync   <= i_hsync;
      s1_vsync   <= i_vsync;
      s1_vsync_q <= s1_vsync;
      s1_hpos    <= i_hpos;
      s1_vpos    <= i_vpos;
      s1_visible <= i_visible;
      o_hsync_n  <= ~s1_hsync;
      o_vsync_n  <= ~s1_vsync;
      o_red      <= red_d;
      o_grn      <= grn_d;
      o_blu      <= blu_d;
      // A strobe landing on the vsync edge bypasses the pending register.
      if (i_pattern_valid && vs_rise) begin
        active_pattern <= i_pattern_sel;
        pending_flag   <= 1'b0;
      end else if (i_pattern_valid) begin
        pending_sel  <= i_pattern_sel;
        pending_flag <= 1'b1;
      end else if (vs_rise && pending_flag) begin
        active_pattern <= pending_sel;
        pending_flag   <= 1'b0;
      end
    end
  end

  assign o_pattern = active_pattern;

endmodule

// File: tb/tb_vga_pattern_pipe.sv
// tb/tb_vga_pattern_pipe.sv - self-checking bench for vga_pattern_pipe
module tb_vga_pattern_pipe;
  localparam int         H_BAR_W       = 80;
  localparam logic [2:0] RESET_PATTERN = 3'd1;

`ifdef VGA_PATTERN_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, hsync, vsync, visible, pvalid;
  logic [9:0] hpos, vpos;
  logic [2:0] psel;
  logic       o_hsync_n, o_vsync_n;
  logic [2:0] o_red, o_grn, o_blu, o_pattern;
  logic [7:0] o_frame_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_pattern_pipe #(.H_BAR_W(H_BAR_W), .RESET_PATTERN(RESET_PATTERN)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hsync(hsync), .i_vsync(vsync),
    .i_hpos(hpos), .i_vpos(vpos), .i_visible(visible),
    .i_pattern_sel(psel), .i_pattern_valid(pvalid),
    .o_hsync_n(o_hsync_n), .o_vsync_n(o_vsync_n),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu),
    .o_frame_count(o_frame_count), .o_pattern(o_pattern)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Pixel colour straight from the pattern definitions, using plain arithmetic.
  function automatic logic [8:0] colour(input logic [2:0] pat, input int h, input int v,
                                        input int f, input logic vis);
    int r, g, b, idx, c;
    r = 0; g = 0; b = 0;
    if (vis) begin
      case (pat)
        3'd1: begin
          r = (h % 8 == 0 || v % 8 == 0) ? 7 : 0;
          g = ((v / 16) % 2 == 1) ? 7 : 0;
          b = ((h / 16) % 2 == 1) ? 7 : 0;
        end
        3'd2: begin
          idx = h / H_BAR_W;
          if (idx > 7) idx = 7;
          r = (idx >= 4) ? 7 : 0;
          g = ((idx / 2) % 2 == 1) ? 7 : 0;
          b = (idx % 2 == 1) ? 7 : 0;
        end
        3'd3: begin
          r = (h / 32) % 8;
          g = (v / 32) % 8;
          b = (f / 4) % 8;
        end
        3'd4: begin
          c = ((h / 32) + (v / 32) + (f / 32)) % 2;
          r = c * 7; g = c * 7; b = c * 7;
        end
        3'd5: begin
          r = 7; g = 7; b = 7;
        end
        default: begin
          r = 0; g = 0; b = 0;
        end
      endcase
    end
    return {r[2:0], g[2:0], b[2:0]};
  endfunction

  // Reference model: a pixel seen at one edge leaves at the next; a frame starts on the
  // edge after the input vsync is first seen high.
  bit         started = 1'b0;
  logic       m_hs, m_vs, m_vis, m_prev_vs;
  int         m_h, m_v;
  logic [2:0] m_pat, m_pend_sel;
  bit         m_pend;
  int         m_frame;
  logic       m_hs_n, m_vs_n;
  logic [8:0] m_rgb;

  always @(posedge clk) begin
    bit frame_start;
    started = 1'b1;
    if (!rst_n) begin
      m_hs = 0; m_vs = 0; m_vis = 0; m_prev_vs = 0; m_h = 0; m_v = 0;
      m_pat = RESET_PATTERN; m_pend = 0; m_pend_sel = 0; m_frame = 0;
      m_hs_n = 1; m_vs_n = 1; m_rgb = 0;
    end else begin
      frame_start = m_vs && !m_prev_vs;
      m_hs_n = !m_hs;
      m_vs_n = !m_vs;
      m_rgb  = colour(m_pat, m_h, m_v, m_frame, m_vis);
      if (pvalid) begin
        if (frame_start) m_pat = psel;
        else begin m_pend_sel = psel; m_pend = 1; end
      end else if (frame_start && m_pend) begin
        m_pat = m_pend_sel;
        m_pend = 0;
      end
      if (pvalid && frame_start) m_pend = 0;
      if (frame_start && ANIM) m_frame = (m_frame + 1) % 256;
      m_prev_vs = m_vs;
      m_hs = hsync; m_vs = vsync; m_vis = visible; m_h = hpos; m_v = vpos;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_hsync_n", o_hsync_n, m_hs_n);
      check("cyc_vsync_n", o_vsync_n, m_vs_n);
      check("cyc_red", o_red, m_rgb[8:6]);
      check("cyc_grn", o_grn, m_rgb[5:3]);
      check("cyc_blu", o_blu, m_rgb[2:0]);
      check("cyc_pattern", o_pattern, m_pat);
      check("cyc_frame", o_frame_count, m_frame[7:0]);
    end
  end

  task automatic pix(input int h, input int v, input logic vis,
                     input int er, input int eg, input int eb, input string name);
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); visible = vis; hsync = 0; vsync = 0;
    @(negedge clk);
    @(negedge clk);
    check({name, "_red"}, o_red, er);
    check({name, "_grn"}, o_grn, eg);
    check({name, "_blu"}, o_blu, eb);
  endtask

  task automatic strobe(input logic [2:0] sel);
    @(negedge clk);
    pvalid = 1; psel = sel;
    @(negedge clk);
    pvalid = 0;
  endtask

  // Short synthetic blanking frame; optional strobe lands on the vs_rise cycle.
  task automatic vframe(input logic with_strobe, input logic [2:0] sel);
    @(negedge clk);
    vsync = 1; hsync = 1; visible = 0;
    @(negedge clk);
    hsync = 0;
    if (with_strobe) begin pvalid = 1; psel = sel; end
    @(negedge clk);
    pvalid = 0;
    @(negedge clk);
    vsync = 0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; hsync = 0; vsync = 0; visible = 0; pvalid = 0;
    hpos = 0; vpos = 0; psel = 0;
    repeat (3) @(negedge clk);
    check("rst_hsync_n", o_hsync_n, 1);
    check("rst_vsync_n", o_vsync_n, 1);
    check("rst_rgb", {o_red, o_grn, o_blu}, 0);
    check("rst_frame", o_frame_count, 0);
    check("rst_pattern", o_pattern, 1);
    rst_n = 1;

    @(negedge clk);
    visible = 1; hpos = 0; vpos = 0;
    @(negedge clk);
    check("lat_1cyc_red", o_red, 0);
    @(negedge clk);
    check("lat_2cyc_red", o_red, 7);

    pix(8, 3, 1, 7, 0, 0, "grid_a");
    pix(16, 17, 1, 7, 7, 7, "grid_b");
    pix(9, 9, 1, 0, 0, 0, "grid_c");

    strobe(3'd5);
    pix(9, 9, 1, 0, 0, 0, "grid_pending");
    check("pend_pattern_hold", o_pattern, 1);
    @(negedge clk);
    vsync = 1; visible = 0;
    @(negedge clk);
    check("pat_before_rise", o_pattern, 1);
    @(negedge clk);
    check("pat_after_rise", o_pattern, 5);
    vsync = 0;
    pix(100, 100, 1, 7, 7, 7, "white");

    strobe(3'd2);
    strobe(3'd4);
    vframe(0, 3'd0);
    check("last_wins", o_pattern, 4);
    pix(32, 0, 1, 7, 7, 7, "chk_light");
    pix(0, 0, 1, 0, 0, 0, "chk_dark");

    vframe(1, 3'd3);
    check("same_cycle_pat", o_pattern, 3);
    check("frame_after3", o_frame_count, ANIM ? 3 : 0);
    pix(224, 64, 1, 7, 2, 0, "gradient");

    vframe(1, 3'd2);
    check("bars_pat", o_pattern, 2);
    pix(79, 10, 1, 0, 0, 0, "bar_79");
    pix(80, 10, 1, 0, 0, 7, "bar_80");
    pix(160, 10, 1, 0, 7, 0, "bar_160");
    pix(639, 10, 1, 7, 7, 7, "bar_639");
    pix(639, 10, 0, 0, 0, 0, "bar_invisible");

    strobe(3'd5);
    @(negedge clk);
    hpos = 300; visible = 1; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("mid_rst_hsync_n", o_hsync_n, 1);
    check("mid_rst_vsync_n", o_vsync_n, 1);
    check("mid_rst_rgb", {o_red, o_grn, o_blu}, 0);
    check("mid_rst_pattern", o_pattern, 1);
    check("mid_rst_frame", o_frame_count, 0);
    vframe(0, 3'd0);
    check("pend_discarded", o_pattern, 1);
    check("frame_first_after_rst", o_frame_count, ANIM ? 1 : 0);

    strobe(3'd4);
    for (int i = 0; i < 255; i++) begin
      vframe(0, 3'd0);
      if (i == 3) pix(32, 0, 1, 7, 7, 7, "chk_frame5");
    end
    check("frame_wrap", o_frame_count, 0);
    pix(32, 0, 1, 7, 7, 7, "chk_frame0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
